// File: rtl/uart_mon_pkg.sv
// Shared constants for the UART monitor: command codes, ASCII values, FSM
// state encoding and the operand count each command expects.
package uart_mon_pkg;

    localparam logic [1:0] CMD_STOP  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_GO    = 2'd3;

    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [2:0] {
        S_CMD,
        S_SEP,
        S_ARG,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [1:0] req_args(input logic [1:0] code);
        logic [1:0] n;
        case (code)
            CMD_WRITE: n = 2'd2;
            CMD_READ:  n = 2'd2;
            CMD_GO:    n = 2'd1;
            default:   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_hex_dec.sv
// Combinational character classifier: hex digits, separators, line endings
// and command letters (case-insensitive).
module uart_hex_dec
    import uart_mon_pkg::*;
(
    input  logic [7:0] rx_char,
    output logic       is_hex,
    output logic [3:0] nibble,
    output logic       is_sp,
    output logic       is_cr,
    output logic       is_lf,
    output logic       cmd_letter_vld,
    output logic [1:0] cmd_letter_code
);

    always_comb begin
        is_hex          = 1'b0;
        nibble          = 4'd0;
        cmd_letter_vld  = 1'b0;
        cmd_letter_code = CMD_STOP;
        is_sp           = (rx_char == ASCII_SP);
        is_cr           = (rx_char == ASCII_CR);
        is_lf           = (rx_char == ASCII_LF);

        if (rx_char >= 8'h30 && rx_char <= 8'h39) begin
            is_hex = 1'b1;
            nibble = rx_char[3:0];
        end else if ((rx_char >= 8'h61 && rx_char <= 8'h66) ||
                     (rx_char >= 8'h41 && rx_char <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
            is_hex = 1'b1;
            nibble = rx_char[3:0] + 4'd9;
        end

        case (rx_char)
            8'h77, 8'h57: begin cmd_letter_vld = 1'b1; cmd_letter_code = CMD_WRITE; end
            8'h72, 8'h52: begin cmd_letter_vld = 1'b1; cmd_letter_code = CMD_READ;  end
            8'h67, 8'h47: begin cmd_letter_vld = 1'b1; cmd_letter_code = CMD_GO;    end
            8'h71, 8'h51: begin cmd_letter_vld = 1'b1; cmd_letter_code = CMD_STOP;  end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_rec_char.sv
// Command-line parser for the UART monitor: turns "<cmd> [hex] [hex] CR"
// into one command with up to two operands over a valid/ready handshake.
module uart_rec_char
    import uart_mon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_char,
    input  logic        rx_en,
    output logic [1:0]  cmd_code,
    output logic [31:0] cmd_arg1,
    output logic [31:0] cmd_arg2,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_err,
    output logic        rx_overrun,
    output logic        crlf_in
);

    logic       is_hex, is_sp, is_cr, is_lf, letter_vld;
    logic [3:0] nibble;
    logic [1:0] letter_code;

    uart_hex_dec u_hex_dec (
        .rx_char         (rx_char),
        .is_hex          (is_hex),
        .nibble          (nibble),
        .is_sp           (is_sp),
        .is_cr           (is_cr),
        .is_lf           (is_lf),
        .cmd_letter_vld  (letter_vld),
        .cmd_letter_code (letter_code)
    );

    state_e      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] arg1_q, arg1_d;
    logic [31:0] arg2_q, arg2_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        sp_seen_q, sp_seen_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic        crlf_q, crlf_d;
    logic        term;
    logic [1:0]  term_cnt;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        acc_d     = acc_q;
        arg1_d    = arg1_q;
        arg2_d    = arg2_q;
        cnt_d     = cnt_q;
        sp_seen_d = sp_seen_q;
        err_d     = 1'b0;
        ovr_d     = 1'b0;
        crlf_d    = 1'b0;
        term      = 1'b0;
        term_cnt  = cnt_q;

        if (rx_en) begin
            case (state_q)
                S_CMD: begin
                    if (letter_vld) begin
                        code_d    = letter_code;
                        cnt_d     = 2'd0;
                        arg1_d    = 32'd0;
                        arg2_d    = 32'd0;
                        sp_seen_d = 1'b0;
                        state_d   = S_SEP;
                    end else if (is_cr) begin
                        crlf_d = 1'b1;
                    end else if (!is_sp && !is_lf) begin
                        state_d = S_ERR;
                    end
                end
                S_SEP: begin
                    if (is_sp) begin
                        sp_seen_d = 1'b1;
                    end else if (is_hex) begin
                        // The letter must be followed by a space; a third operand is refused
                        if (!sp_seen_q || cnt_q == 2'd2) begin
                            state_d = S_ERR;
                        end else begin
                            acc_d   = {28'd0, nibble};
                            state_d = S_ARG;
                        end
                    end else if (is_cr) begin
                        term = 1'b1;
                    end else if (!is_lf) begin
                        state_d = S_ERR;
                    end
                end
                S_ARG: begin
                    if (is_hex) begin
                        acc_d = {acc_q[27:0], nibble};
                    end else if (is_sp || is_cr) begin
                        if (cnt_q == 2'd0) arg1_d = acc_q;
                        else               arg2_d = acc_q;
                        cnt_d     = cnt_q + 2'd1;
                        sp_seen_d = 1'b1;
                        term_cnt  = cnt_q + 2'd1;
                        term      = is_cr;
                        state_d   = S_SEP;
                    end else if (!is_lf) begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    if (is_cr) begin
                        err_d   = 1'b1;
                        crlf_d  = 1'b1;
                        state_d = S_CMD;
                    end
                end
                S_DONE:  ovr_d = 1'b1;
                default: state_d = S_CMD;
            endcase
        end

        if (term) begin
            crlf_d = 1'b1;
            if (term_cnt == req_args(code_q)) begin
                state_d = S_DONE;
            end else begin
                err_d   = 1'b1;
                state_d = S_CMD;
            end
        end

        if (state_q == S_DONE && cmd_ready) state_d = S_CMD;

        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CMD;
            code_q    <= 2'd0;
            acc_q     <= 32'd0;
            arg1_q    <= 32'd0;
            arg2_q    <= 32'd0;
            cnt_q     <= 2'd0;
            sp_seen_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            crlf_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            acc_q     <= acc_d;
            arg1_q    <= arg1_d;
            arg2_q    <= arg2_d;
            cnt_q     <= cnt_d;
            sp_seen_q <= sp_seen_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            crlf_q    <= crlf_d;
        end
    end

    assign cmd_code   = code_q;
    assign cmd_arg1   = arg1_q;
    assign cmd_arg2   = arg2_q;
    assign cmd_valid  = valid_q;
    assign cmd_err    = err_q;
    assign rx_overrun = ovr_q;
    assign crlf_in    = crlf_q;

endmodule

// File: tb/tb_uart_rec_char.sv
// Scoreboard bench for uart_rec_char: expected commands are queued as lines
// are typed and compared when the parser presents them.
module tb_uart_rec_char;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_char = 8'd0;
    logic        rx_en = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_code;
    logic [31:0] cmd_arg1, cmd_arg2;
    logic        cmd_valid, cmd_err, rx_overrun, crlf_in;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] arg1;
        logic [31:0] arg2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_crlf = 0, n_err = 0, n_ovr = 0, n_vld = 0;

    uart_rec_char dut (
        .clk        (clk),
        .rst        (rst),
        .rx_char    (rx_char),
        .rx_en      (rx_en),
        .cmd_code   (cmd_code),
        .cmd_arg1   (cmd_arg1),
        .cmd_arg2   (cmd_arg2),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_err    (cmd_err),
        .rx_overrun (rx_overrun),
        .crlf_in    (crlf_in)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (crlf_in)    n_crlf <= n_crlf + 1;
        if (cmd_err)    n_err  <= n_err + 1;
        if (rx_overrun) n_ovr  <= n_ovr + 1;
        if (cmd_valid)  n_vld  <= n_vld + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        rx_char = c;
        rx_en   = 1'b1;
        tick();
        rx_en   = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        send_char(8'h0d);
    endtask

    // Line expected to decode; hold>0 keeps ready low that many cycles and
    // injects one dropped character on the third held cycle.
    task automatic run_good(input string s, input logic [1:0] code, input logic [31:0] a1,
                            input logic [31:0] a2, input int hold);
        exp_t e;
        int   c0, e0, o0;
        exp_q.push_back('{code: code, arg1: a1, arg2: a2});
        c0 = n_crlf; e0 = n_err; o0 = n_ovr;
        cmd_ready = (hold == 0);
        send_line(s);
        check_eq({s, " valid_latency"}, 32'(cmd_valid), 32'd1);
        e = exp_q.pop_front();
        check_eq({s, " code"}, 32'(cmd_code), 32'(e.code));
        check_eq({s, " arg1"}, cmd_arg1, e.arg1);
        check_eq({s, " arg2"}, cmd_arg2, e.arg2);
        for (int k = 0; k < hold; k++) begin
            if (k == 2) send_char(8'h35);
            else        tick();
            check_eq({s, " hold_valid"}, 32'(cmd_valid), 32'd1);
            check_eq({s, " hold_arg1"}, cmd_arg1, e.arg1);
            check_eq({s, " hold_arg2"}, cmd_arg2, e.arg2);
        end
        cmd_ready = 1'b1;
        tick();
        check_eq({s, " valid_after_xfer"}, 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;
        check_eq({s, " crlf_pulses"}, 32'(n_crlf - c0), 32'd1);
        check_eq({s, " err_pulses"}, 32'(n_err - e0), 32'd0);
        check_eq({s, " overruns"}, 32'(n_ovr - o0), (hold > 2) ? 32'd1 : 32'd0);
    endtask

    task automatic run_bad(input string s);
        int c0, e0, v0;
        c0 = n_crlf; e0 = n_err; v0 = n_vld;
        cmd_ready = 1'b0;
        send_line(s);
        tick();
        tick();
        check_eq({s, " err_pulses"}, 32'(n_err - e0), 32'd1);
        check_eq({s, " crlf_pulses"}, 32'(n_crlf - c0), 32'd1);
        check_eq({s, " valid_cycles"}, 32'(n_vld - v0), 32'd0);
    endtask

    initial begin
        int o0, c0, e0;
        exp_t e;

        rst = 1'b1;
        repeat (3) tick();
        check_eq("reset valid", 32'(cmd_valid), 32'd0);
        check_eq("reset code", 32'(cmd_code), 32'd0);
        check_eq("reset arg1", cmd_arg1, 32'd0);
        check_eq("reset arg2", cmd_arg2, 32'd0);
        check_eq("reset pulses", 32'({cmd_err, rx_overrun, crlf_in}), 32'd0);
        rst = 1'b0;
        tick();

        run_good("w 00001000 deadbeef", 2'd1, 32'h0000_1000, 32'hDEAD_BEEF, 0);
        run_good("R 100 1FF", 2'd2, 32'h100, 32'h1FF, 5);
        run_good("g 123456789", 2'd3, 32'h2345_6789, 32'd0, 0);

        run_bad("x 10");
        run_bad("w 10");
        run_bad("q 5");
        run_bad("g 1 2 3");
        run_bad("w1 2");

        // Overrun on a pending STOP command
        exp_q.push_back('{code: 2'd0, arg1: 32'd0, arg2: 32'd0});
        o0 = n_ovr;
        cmd_ready = 1'b0;
        send_line("q ");
        check_eq("ovr valid", 32'(cmd_valid), 32'd1);
        send_char(8'h61);
        tick();
        e = exp_q.pop_front();
        check_eq("ovr pulses", 32'(n_ovr - o0), 32'd1);
        check_eq("ovr still_valid", 32'(cmd_valid), 32'd1);
        check_eq("ovr code", 32'(cmd_code), 32'(e.code));
        check_eq("ovr arg1", cmd_arg1, e.arg1);
        check_eq("ovr arg2", cmd_arg2, e.arg2);
        cmd_ready = 1'b1;
        tick();
        check_eq("ovr valid_after_xfer", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;

        // Reset mid-line abandons it
        send_char(8'h77); send_char(8'h20); send_char(8'h31); send_char(8'h32);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_good("q", 2'd0, 32'd0, 32'd0, 0);

        // Reset while a command is pending drops cmd_valid next cycle
        send_line("g 5");
        check_eq("rst_done valid", 32'(cmd_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("rst_done valid_cleared", 32'(cmd_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Extra spacing and a trailing LF
        run_good("  w  4   8", 2'd1, 32'd4, 32'd8, 0);
        c0 = n_crlf; e0 = n_err; o0 = n_ovr;
        send_char(8'h0a);
        tick();
        check_eq("lf no_pulses", 32'((n_crlf - c0) + (n_err - e0) + (n_ovr - o0)), 32'd0);
        check_eq("lf no_valid", 32'(cmd_valid), 32'd0);
        run_good("r 0 a", 2'd2, 32'd0, 32'hA, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rec_char.md
# uart_rec_char

Receive-side decoder of the UART monitor. It takes ASCII characters from the UART RX interface one at a time and parses a command line of the form `<cmd> [hex] [hex] CR`. It delivers one decoded command, with up to two 32-bit operands, to the monitor control block over a valid/ready handshake. It also raises a CR pulse so the send path emits a line break.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_char` in 8: received ASCII character.
- `rx_en` in 1: `rx_char` valid this cycle (single-cycle strobe).
- `cmd_code` out 2: decoded command (see Structure).
- `cmd_arg1` out 32: first operand (address / start address / PC).
- `cmd_arg2` out 32: second operand (write data / end address).
- `cmd_valid` out 1: command available; held until accepted.
- `cmd_ready` in 1: control accepts the command when `cmd_valid & cmd_ready`.
- `cmd_err` out 1: 1-cycle pulse on a malformed line.
- `rx_overrun` out 1: 1-cycle pulse when a character is dropped.
- `crlf_in` out 1: 1-cycle pulse to the send path after any CR is consumed.

## Operation
- Character classes:
  - `0-9`, `a-f`, `A-F`: hex nibble.
  - 0x20: separator.
  - 0x0d: terminator.
  - 0x0a: ignored in every state.
  - Anything else: error.
- Command letters, case-insensitive:
  - `w` (WRITE): 2 arguments.
  - `r` (READ): 2 arguments.
  - `g` (GO): 1 argument.
  - `q` (STOP): 0 arguments.
- FSM states: S_CMD, S_SEP, S_ARG, S_DONE, S_ERR.
- S_CMD:
  - Valid letter: latch the code, clear the argument count, go to S_SEP.
  - CR: empty line; pulse `crlf_in` only and stay in S_CMD.
  - Space: ignored.
  - Other: go to S_ERR.
- S_SEP (a separator is required after the letter and between arguments):
  - Space: stay.
  - Hex: start a new argument, `acc <= {28'd0, nibble}`, go to S_ARG.
  - CR: terminate.
  - Other: go to S_ERR.
- S_ARG:
  - Hex: `acc <= {acc[27:0], nibble}`. More than 8 digits keeps the last 8; this is not an error.
  - Space: commit `acc` to arg1 or arg2, increment the count, go to S_SEP.
  - CR: commit, then terminate.
  - Other: go to S_ERR.
  - A third argument is an error: the transition to S_ERR is taken on its first digit.
- Terminate:
  - If the argument count equals the count required by the command, go to S_DONE.
  - Otherwise pulse `cmd_err` and go to S_CMD.
  - Either way, pulse `crlf_in`.
- S_ERR: discard characters until CR, then pulse `cmd_err` and `crlf_in` and go to S_CMD.
- S_DONE:
  - `cmd_valid` = 1.
  - Outputs stay stable until `cmd_ready`, then go to S_CMD.
  - Any `rx_en` while in S_DONE is dropped and pulses `rx_overrun`. This includes the cycle in which `cmd_ready` is high.
- Unused operands: `cmd_arg2` is 0 for `g`; both operands are 0 for `q`.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in S_CMD.
  - Accumulator and counters cleared.
- `rst` mid-line or while in S_DONE:
  - The line is abandoned.
  - `cmd_valid` falls on the cycle after `rst` is sampled.
- Latency:
  - `cmd_valid` rises 1 cycle after the terminating CR is sampled with `rx_en`.
  - `crlf_in` and `cmd_err` pulse in that same cycle.
- Handshake:
  - Transfer occurs on a cycle with `cmd_valid & cmd_ready`.
  - `cmd_valid` is low the following cycle.
  - `cmd_ready` without `cmd_valid` has no effect.
- Throughput: a character can be accepted every cycle in every state except S_DONE.
- `rx_en` low: no state change.

## Structure
- Package `uart_mon_pkg`:
  - Command codes: `CMD_STOP=2'd0`, `CMD_WRITE=2'd1`, `CMD_READ=2'd2`, `CMD_GO=2'd3`.
  - ASCII constants: CR, LF, SP.
  - FSM state encoding.
  - Required argument count per command.
- Sub-module `uart_hex_dec` (combinational):
  - Input `rx_char`.
  - Outputs `is_hex`, `nibble[3:0]`, `is_sp`, `is_cr`, `is_lf`, `cmd_letter_vld`, `cmd_letter_code[1:0]`.
- Top: FSM, 32-bit accumulator, arg registers, 2-bit argument counter, handshake and pulse registers.

## Test plan
- `w 00001000 deadbeef CR`, `cmd_ready`=1:
  - `cmd_valid` 1 cycle after CR, `cmd_code`=1, `arg1`=0x00001000, `arg2`=0xDEADBEEF.
  - `crlf_in` pulses once.
- `R 100 1FF CR` with `cmd_ready` held low 5 cycles:
  - `cmd_code`=2, `arg1`=0x100, `arg2`=0x1FF.
  - `cmd_valid` stable for 6 cycles, drops the cycle after `ready`.
- `g 123456789 CR`: `cmd_code`=3, `arg1`=0x23456789, `arg2`=0.
- Error lines, each giving a `cmd_err` pulse, no `cmd_valid`, and a `crlf_in` pulse:
  - `x 10 CR`
  - `w 10 CR`
  - `q 5 CR`
  - `g 1 2 3 CR`
  - `w1 2 CR`
- Overrun and reset:
  - `q CR`, then `a` while `cmd_valid` is high and `ready`=0 → `rx_overrun` pulse, operands unchanged.
  - `rst` during `w 12` → next line `q CR` decodes cleanly with `cmd_code`=0.
- LF and spacing: `  w  4   8 CR LF` → WRITE, `arg1`=4, `arg2`=8, and the LF has no effect.
